fetch_pipeline: RTL and testbench

// - Parametrised instruction-fetch pipeline between program_sequencer/program_memory and instruction_decoder.
// - Tags each issued pm address and realigns it with returning memory data after MEM_LAT cycles.
// - Carries the pair through PIPE_DEPTH register stages, each with a valid bit.
// - Kills wrong-path slots on redirect; bubbles reach the decoder as NOP_OPCODE.
// - Adds a decode-side stall and bubble statistics, which the fixed two-stage flush path lacks.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_pipeline_if.sv | 27 ++
 rtl/fetch_stage.sv | 23 ++
 rtl/fetch_pipeline.sv | 92 +++++++++
 tb/tb_fetch_pipeline.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch pipeline.
package fetch_pkg;

    localparam int FETCH_DATA_W = 8;
    localparam int FETCH_ADDR_W = 8;
    localparam logic [7:0] NOP_C8 = 8'hC8;

    typedef struct packed {
        logic                    valid;
        logic                    killed;
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_slot_t;

    localparam fetch_slot_t KILLED_SLOT = '{valid: 1'b0, killed: 1'b1, addr: '0, data: '0};

endpackage

// File: rtl/fetch_pipeline_if.sv
// Sequencer/memory/decoder-side signals of the fetch pipeline.
interface fetch_pipeline_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int COUNT_W = 16
);
    logic               issue_valid;
    logic [ADDR_W-1:0]  pm_addr_in;
    logic [DATA_W-1:0]  pm_data_in;
    logic               redirect;
    logic               stall;
    logic [DATA_W-1:0]  ir_out;
    logic [ADDR_W-1:0]  ir_addr_out;
    logic               ir_valid;
    logic               flush_active;
    logic [COUNT_W-1:0] bubble_count;

    modport master (
        output issue_valid, pm_addr_in, pm_data_in, redirect, stall,
        input  ir_out, ir_addr_out, ir_valid, flush_active, bubble_count
    );

    modport slave (
        input  issue_valid, pm_addr_in, pm_data_in, redirect, stall,
        output ir_out, ir_addr_out, ir_valid, flush_active, bubble_count
    );
endinterface

// File: rtl/fetch_stage.sv
// One fetch slot register; kill takes priority over load so a redirect lands even while stalled.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        kill,
    input  fetch_slot_t d,
    output fetch_slot_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (kill) begin
            q <= KILLED_SLOT;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pipeline.sv
// Instruction-fetch pipeline: tags issued addresses, joins them with memory data after
// MEM_LAT cycles, and carries the pair through PIPE_DEPTH killable stages to the decoder.
module fetch_pipeline
    import fetch_pkg::*;
#(
    parameter int                DATA_W     = FETCH_DATA_W,
    parameter int                ADDR_W     = FETCH_ADDR_W,
    parameter int                MEM_LAT    = 1,
    parameter int                PIPE_DEPTH = 2,
    parameter logic [DATA_W-1:0] NOP_OPCODE = NOP_C8,
    parameter int                COUNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    fetch_pipeline_if.slave bus
);

    fetch_slot_t            tag_d [MEM_LAT];
    fetch_slot_t            tag_q [MEM_LAT];
    fetch_slot_t            stg_d [PIPE_DEPTH];
    fetch_slot_t            stg_q [PIPE_DEPTH];
    logic [MEM_LAT-1:0]     tag_killed;
    logic [PIPE_DEPTH-1:0]  stg_killed;
    logic                   load;
    logic [COUNT_W-1:0]     bubble_q;

    assign load = ~bus.stall;

    // Tag pipe: same slot register as the data stages, data field held at zero.
    for (genvar i = 0; i < MEM_LAT; i++) begin : g_tag
        if (i == 0) begin : g_issue
            assign tag_d[i] = '{valid: bus.issue_valid, killed: 1'b0, addr: bus.pm_addr_in, data: '0};
        end else begin : g_shift
            assign tag_d[i] = tag_q[i-1];
        end

        fetch_stage u_tag (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .kill  (bus.redirect),
            .d     (tag_d[i]),
            .q     (tag_q[i])
        );

        assign tag_killed[i] = tag_q[i].killed;
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_join
            // The oldest tag meets the memory word addressed MEM_LAT cycles earlier.
            always_comb begin
                stg_d[k]      = tag_q[MEM_LAT-1];
                stg_d[k].data = bus.pm_data_in;
            end
        end else begin : g_shift
            assign stg_d[k] = stg_q[k-1];
        end

        fetch_stage u_stage (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .kill  (bus.redirect),
            .d     (stg_d[k]),
            .q     (stg_q[k])
        );

        assign stg_killed[k] = stg_q[k].killed;
    end

    always_comb begin
        bus.ir_valid     = stg_q[PIPE_DEPTH-1].valid;
        bus.ir_out       = NOP_OPCODE;
        bus.ir_addr_out  = {ADDR_W{1'b0}};
        if (stg_q[PIPE_DEPTH-1].valid) begin
            bus.ir_out      = stg_q[PIPE_DEPTH-1].data;
            bus.ir_addr_out = stg_q[PIPE_DEPTH-1].addr;
        end
        bus.flush_active = (|tag_killed) | (|stg_killed);
        bus.bubble_count = bubble_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_q <= '0;
        end else if (!stg_q[PIPE_DEPTH-1].valid && !bus.stall && bubble_q != '1) begin
            bubble_q <= bubble_q + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_pipeline.sv
// Self-checking bench for fetch_pipeline against a queue-based reference model.
module tb_fetch_pipeline;

    localparam logic [7:0] NOP = 8'hC8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_pipeline_if #(.DATA_W(8), .ADDR_W(8), .COUNT_W(16)) b0 ();
    fetch_pipeline_if #(.DATA_W(8), .ADDR_W(8), .COUNT_W(3))  b1 ();

    fetch_pipeline #(.MEM_LAT(1), .PIPE_DEPTH(2), .COUNT_W(16)) u_dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b0)
    );

    fetch_pipeline #(.MEM_LAT(2), .PIPE_DEPTH(3), .COUNT_W(3)) u_dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (b1)
    );

    typedef struct {
        bit         v;
        bit         k;
        logic [7:0] a;
    } ref_slot_t;

    // Reference: one queue entry per in-flight slot, index 0 is what the decoder sees.
    ref_slot_t   mq[$];
    logic [7:0]  memq[$];
    int unsigned sel, lat, depth, cnt, cnt_max;
    int unsigned checks = 0, passes = 0;

    logic        o_v, o_f, e_v, e_f;
    logic [7:0]  o_ir, o_a, e_ir, e_a;
    logic [15:0] o_cnt, e_cnt;

    task automatic expect_update();
        e_v   = mq[0].v;
        e_a   = e_v ? mq[0].a : 8'h00;
        e_ir  = e_v ? 8'(8'h10 + mq[0].a) : NOP;
        e_f   = 1'b0;
        foreach (mq[i]) if (mq[i].k) e_f = 1'b1;
        e_cnt = 16'(cnt);
    endtask

    task automatic model_reset(input int unsigned s);
        sel     = s;
        lat     = (s == 0) ? 1 : 2;
        depth   = (s == 0) ? 2 : 3;
        cnt_max = (s == 0) ? 65535 : 7;
        cnt     = 0;
        mq.delete();
        memq.delete();
        repeat (lat + depth) mq.push_back('{1'b0, 1'b0, 8'h00});
        repeat (lat) memq.push_back(8'h00);
        expect_update();
    endtask

    task automatic observe();
        if (sel == 0) begin
            o_v = b0.ir_valid; o_ir = b0.ir_out; o_a = b0.ir_addr_out;
            o_f = b0.flush_active; o_cnt = b0.bubble_count;
        end else begin
            o_v = b1.ir_valid; o_ir = b1.ir_out; o_a = b1.ir_addr_out;
            o_f = b1.flush_active; o_cnt = {13'd0, b1.bubble_count};
        end
    endtask

    // Drive one cycle from the falling edge, advance model and memory, sample at the next falling edge.
    task automatic step(input bit iv, input logic [7:0] a, input bit red, input bit st);
        if (sel == 0) begin
            b0.issue_valid = iv; b0.pm_addr_in = a; b0.redirect = red; b0.stall = st;
            b0.pm_data_in  = 8'(8'h10 + memq[lat-1]);
        end else begin
            b1.issue_valid = iv; b1.pm_addr_in = a; b1.redirect = red; b1.stall = st;
            b1.pm_data_in  = 8'(8'h10 + memq[lat-1]);
        end
        if (!mq[0].v && !st && cnt < cnt_max) cnt++;
        if (red) begin
            foreach (mq[i]) mq[i] = '{1'b0, 1'b1, 8'h00};
        end else if (!st) begin
            void'(mq.pop_front());
            mq.push_back('{iv, 1'b0, a});
        end
        @(posedge clk);
        if (!st) begin
            void'(memq.pop_back());
            memq.push_front(a);
        end
        @(negedge clk);
        observe();
        expect_update();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        sel = 0; observe();
        checks++;
        if ({o_v, o_ir, o_a, o_f, o_cnt} !== {1'b0, NOP, 8'h00, 1'b0, 16'd0})
            $display("FAIL reset_dut0 got v=%b ir=%h a=%h fl=%b bc=%0d want v=0 ir=c8 a=00 fl=0 bc=0", o_v, o_ir, o_a, o_f, o_cnt);
        else passes++;
        sel = 1; observe();
        checks++;
        if ({o_v, o_ir, o_a, o_f, o_cnt} !== {1'b0, NOP, 8'h00, 1'b0, 16'd0})
            $display("FAIL reset_dut1 got v=%b ir=%h a=%h fl=%b bc=%0d want v=0 ir=c8 a=00 fl=0 bc=0", o_v, o_ir, o_a, o_f, o_cnt);
        else passes++;
        rst_n = 1'b1;
        model_reset(0);
    endtask

    task automatic test_straight();
        int first = -1;
        for (int j = 0; j < 10; j++) begin
            step(j < 6, (j < 6) ? 8'(j) : 8'h00, 1'b0, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL straight[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (o_v && first < 0) first = j;
        end
        checks++;
        if (first != 2) $display("FAIL straight_latency got %0d want 2", first);
        else passes++;
    endtask

    task automatic test_redirect();
        logic [7:0] a_t [11] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0};
        int bub = 0, bad = 0;
        bit tgt = 1'b0;
        for (int j = 0; j < 11; j++) begin
            step(j < 7, a_t[j], j == 3, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL redirect[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (o_v && o_a >= 8'd1 && o_a <= 8'd3) bad++;
            if (j >= 3 && !o_v && !tgt) bub++;
            if (o_v && o_a == 8'd8) tgt = 1'b1;
        end
        checks++;
        if (bub != 3 || bad != 0 || !tgt)
            $display("FAIL redirect_bubbles got bubbles=%0d killed_seen=%0d target=%b want bubbles=3 killed_seen=0 target=1", bub, bad, tgt);
        else passes++;
    endtask

    task automatic test_stall();
        logic [15:0] cnt_before;
        logic [7:0]  seen[$];
        logic [7:0]  want[$] = '{8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        for (int j = 0; j < 5; j++) step(1'b1, 8'(j), 1'b0, 1'b0);
        cnt_before = o_cnt;
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 8'd5, 1'b0, 1'b1);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt} || o_a !== 8'd2)
                $display("FAIL stall_hold[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
        end
        checks++;
        if (o_cnt !== cnt_before) $display("FAIL stall_count got %0d want %0d", o_cnt, cnt_before);
        else passes++;
        for (int j = 0; j < 7; j++) begin
            step(j < 3, (j < 3) ? 8'(5 + j) : 8'h00, 1'b0, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL stall_resume[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (o_v) seen.push_back(o_a);
        end
        checks++;
        if (seen != want) $display("FAIL stall_order got %p want %p", seen, want);
        else passes++;
    endtask

    task automatic test_redirect_stall();
        logic [15:0] cnt_at_red = '0;
        int          delta = -1;
        for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h30 + j), 1'b0, 1'b0);
        for (int j = 0; j < 11; j++) begin
            case (j)
                0:       step(1'b1, 8'h33, 1'b1, 1'b1);
                1, 2:    step(1'b1, 8'h40, 1'b0, 1'b1);
                3:       step(1'b1, 8'h40, 1'b0, 1'b0);
                4:       step(1'b1, 8'h41, 1'b0, 1'b0);
                default: step(1'b0, 8'h00, 1'b0, 1'b0);
            endcase
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL redir_stall[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (j == 0) cnt_at_red = o_cnt;
            if (o_v && o_a == 8'h40 && delta < 0) delta = int'(o_cnt - cnt_at_red);
        end
        checks++;
        if (delta != 3) $display("FAIL redir_stall_bubbles got %0d want 3", delta);
        else passes++;
    endtask

    task automatic test_random();
        bit         iv, red, st;
        logic [7:0] a;
        for (int j = 0; j < 200; j++) begin
            iv  = $urandom_range(0, 3) != 0;
            a   = 8'($urandom);
            red = $urandom_range(0, 9) == 0;
            st  = $urandom_range(0, 4) == 0;
            step(iv, a, red, st);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL random[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        for (int j = 0; j < 3; j++) step(1'b1, 8'(8'h50 + j), 1'b0, 1'b0);
        step(1'b1, 8'h53, 1'b1, 1'b0);
        checks++;
        if (o_f !== 1'b1) $display("FAIL async_pre_flush got fl=%b want fl=1", o_f);
        else passes++;
        #2 rst_n = 1'b0;
        #1 observe();
        checks++;
        if ({o_v, o_ir, o_a, o_f, o_cnt} !== {1'b0, NOP, 8'h00, 1'b0, 16'd0})
            $display("FAIL async_reset got v=%b ir=%h a=%h fl=%b bc=%0d want v=0 ir=c8 a=00 fl=0 bc=0", o_v, o_ir, o_a, o_f, o_cnt);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_param_sweep();
        int first = -1, bub = 0;
        bit tgt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset(1);
        for (int j = 0; j < 10; j++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL sweep_idle[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
        end
        checks++;
        if (o_cnt !== 16'd7) $display("FAIL sweep_saturate got %0d want 7", o_cnt);
        else passes++;
        for (int j = 0; j < 7; j++) begin
            step(j == 0, 8'h60, 1'b0, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL sweep_lat[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (o_v && first < 0) first = j;
        end
        checks++;
        if (first != 4) $display("FAIL sweep_latency got %0d want 4", first);
        else passes++;
        for (int j = 0; j < 12; j++) begin
            step(j < 6, (j < 4) ? 8'(8'h70 + j) : 8'(8'h7C + j), j == 3, 1'b0);
            checks++;
            if ({o_v, o_ir, o_a, o_f, o_cnt} !== {e_v, e_ir, e_a, e_f, e_cnt})
                $display("FAIL sweep_redir[%0d] got v=%b ir=%h a=%h fl=%b bc=%0d want v=%b ir=%h a=%h fl=%b bc=%0d", j, o_v, o_ir, o_a, o_f, o_cnt, e_v, e_ir, e_a, e_f, e_cnt);
            else passes++;
            if (j >= 3 && !o_v && !tgt) bub++;
            if (o_v && o_a == 8'h80) tgt = 1'b1;
        end
        checks++;
        if (bub != 5 || !tgt) $display("FAIL sweep_bubbles got bubbles=%0d target=%b want bubbles=5 target=1", bub, tgt);
        else passes++;
    endtask

    initial begin
        b0.issue_valid = 1'b0; b0.pm_addr_in = '0; b0.pm_data_in = '0; b0.redirect = 1'b0; b0.stall = 1'b0;
        b1.issue_valid = 1'b0; b1.pm_addr_in = '0; b1.pm_data_in = '0; b1.redirect = 1'b0; b1.stall = 1'b0;
        test_reset();
        test_straight();
        test_redirect();
        test_stall();
        test_redirect_stall();
        test_random();
        test_async_reset();
        test_param_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
